// File: rtl/booth_seq_pkg.sv
// Shared types and 7-segment helpers for the sequential Booth multiplier.
package booth_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned SEG_CODE_W = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 10;

  // Segment codes a..g (MSB = a) for digits 0..9.
  localparam logic [SEG_CODE_W-1:0] SEG_DIGIT [NUM_DIGITS] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  // Returns {valid, bcd}; bcd is zero when the code matches no digit.
  function automatic logic [BCD_W:0] seg_decode(input logic [SEG_CODE_W-1:0] code);
    logic [BCD_W:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (code == SEG_DIGIT[i]) r = {1'b1, BCD_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_step.sv
// One radix-2 Booth step: conditional add/subtract of M, then arithmetic shift of {A,Q,Qm1}.
module booth_seq_ctrl_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_qm1,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_a_nx,
  output logic [WIDTH-1:0] o_q_nx,
  output logic             o_qm1_nx
);

  logic [WIDTH-1:0] w_sum;

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_qm1})
      2'b01:   w_sum = i_a + i_m;
      2'b10:   w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
  end

  assign o_a_nx   = {w_sum[WIDTH-1], w_sum[WIDTH-1:1]};
  assign o_q_nx   = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_qm1_nx = i_q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential Booth multiplier taking signed 2-digit 7-segment operands; start/busy/done handshake.
module booth_seq_ctrl
  import booth_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEG_W = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*SEG_W:0]     x_in,
  input  logic [2*SEG_W:0]     y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned OP_W  = 2*SEG_W + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] TEN      = WIDTH'(10);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nx;

  logic [OP_W-1:0]    r_x, r_y;
  logic [WIDTH-1:0]   r_a, r_q, r_m;
  logic               r_qm1;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done, r_err;
  logic [2*WIDTH-1:0] r_product;

  logic [BCD_W:0]   w_xt, w_xu, w_yt, w_yu;
  logic             w_ops_valid;
  logic [WIDTH-1:0] w_x_mag, w_y_mag, w_x_val, w_y_val;
  logic [WIDTH-1:0] w_a_nx, w_q_nx;
  logic             w_qm1_nx;
  logic             w_last;
  logic             w_capture, w_load, w_fail, w_step, w_finish;

  // Operand decode from the captured copies.
  assign w_xt = seg_decode(r_x[2*SEG_W-1:SEG_W]);
  assign w_xu = seg_decode(r_x[SEG_W-1:0]);
  assign w_yt = seg_decode(r_y[2*SEG_W-1:SEG_W]);
  assign w_yu = seg_decode(r_y[SEG_W-1:0]);

  assign w_ops_valid = w_xt[BCD_W] & w_xu[BCD_W] & w_yt[BCD_W] & w_yu[BCD_W];

  assign w_x_mag = WIDTH'(w_xt[BCD_W-1:0]) * TEN + WIDTH'(w_xu[BCD_W-1:0]);
  assign w_y_mag = WIDTH'(w_yt[BCD_W-1:0]) * TEN + WIDTH'(w_yu[BCD_W-1:0]);
  assign w_x_val = r_x[2*SEG_W] ? -w_x_mag : w_x_mag;
  assign w_y_val = r_y[2*SEG_W] ? -w_y_mag : w_y_mag;

  assign w_last = (r_cnt == LAST_CNT);

  booth_seq_ctrl_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a      (r_a),
    .i_q      (r_q),
    .i_qm1    (r_qm1),
    .i_m      (r_m),
    .o_a_nx   (w_a_nx),
    .o_q_nx   (w_q_nx),
    .o_qm1_nx (w_qm1_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = LOAD;
      LOAD:    w_state_nx = w_ops_valid ? STEP : DONE;
      STEP:    if (w_last) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    w_capture = 1'b0;
    w_load    = 1'b0;
    w_fail    = 1'b0;
    w_step    = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE: w_capture = start;
      LOAD: begin
        busy   = 1'b1;
        w_load = w_ops_valid;
        w_fail = ~w_ops_valid;
      end
      STEP: begin
        busy     = 1'b1;
        w_step   = 1'b1;
        w_finish = w_last;
      end
      DONE:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath and output registers; done rises on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= w_finish | w_fail;
      if (w_capture) begin
        r_x <= x_in;
        r_y <= y_in;
      end
      if (w_load) begin
        r_m   <= w_x_val;
        r_q   <= w_y_val;
        r_a   <= '0;
        r_qm1 <= 1'b0;
        r_cnt <= '0;
      end
      if (w_fail) begin
        r_err     <= 1'b1;
        r_product <= '0;
      end
      if (w_step) begin
        r_a   <= w_a_nx;
        r_q   <= w_q_nx;
        r_qm1 <= w_qm1_nx;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_finish) begin
        r_product <= {w_a_nx, w_q_nx};
        r_err     <= 1'b0;
      end
    end
  end

  assign done    = r_done;
  assign err     = r_err;
  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: directed corner cases plus random operands against an integer-arithmetic model.
module tb_booth_seq_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned OP_W  = 2*SEG_W + 1;
  localparam int unsigned P_W   = 2*WIDTH;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [OP_W-1:0] x_in = '0;
  logic [OP_W-1:0] y_in = '0;
  logic            busy, done, err;
  logic [P_W-1:0]  product;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x_in    (x_in),
    .y_in    (y_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .product (product)
  );

  function automatic logic [OP_W-1:0] enc(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return {(v < 0) ? 1'b1 : 1'b0, SEG_TAB[m / 10], SEG_TAB[m % 10]};
  endfunction

  function automatic int dig(input logic [6:0] c);
    int d;
    d = -1;
    for (int i = 0; i < 10; i++) if (c == SEG_TAB[i]) d = i;
    return d;
  endfunction

  // Reference: decode digits, form signed integers, multiply.
  function automatic void model(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y,
                                output logic [P_W-1:0] p, output logic e);
    int xt, xu, yt, yu, xv, yv;
    xt = dig(x[13:7]); xu = dig(x[6:0]);
    yt = dig(y[13:7]); yu = dig(y[6:0]);
    if (xt < 0 || xu < 0 || yt < 0 || yu < 0) begin
      p = '0;
      e = 1'b1;
    end else begin
      xv = (10*xt + xu) * (x[14] ? -1 : 1);
      yv = (10*yt + yu) * (y[14] ? -1 : 1);
      p  = P_W'(xv * yv);
      e  = 1'b0;
    end
  endfunction

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] r;
    r = enc(int'($urandom_range(0, 198)) - 99);
    if ($urandom_range(0, 7) == 0) r[13:7] = 7'($urandom);
    if ($urandom_range(0, 7) == 0) r[6:0]  = 7'($urandom);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from start to return to IDLE; disturb pulses start and scrambles operands mid-op.
  task automatic run_op(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y, input bit disturb);
    logic [P_W-1:0] ep;
    logic           ee;
    int             lat;
    model(x, y, ep, ee);
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (disturb) begin
        start = 1'b1;
        x_in  = OP_W'($urandom);
        y_in  = OP_W'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check("done_latency", 32'(lat), ee ? 32'd1 : 32'(WIDTH + 1));
    check("product", 32'(product), 32'(ep));
    check("err", 32'(err), 32'(ee));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("product_hold", 32'(product), 32'(ep));
  endtask

  initial begin
    logic [OP_W-1:0] neg0;
    logic [OP_W-1:0] bad;
    logic [P_W-1:0]  ep;
    logic            ee;
    int              first, second;

    neg0 = {1'b1, SEG_TAB[0], SEG_TAB[0]};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op({1'b0, 7'b0110000, 7'b1101101}, {1'b1, 7'b1111110, 7'b1110000}, 1'b0);
    run_op(enc(99), enc(99), 1'b0);
    run_op(enc(-99), enc(-99), 1'b0);
    run_op(enc(99), enc(-99), 1'b0);
    run_op(neg0, enc(-45), 1'b0);
    run_op(enc(45), neg0, 1'b0);
    run_op(neg0, neg0, 1'b0);

    bad = enc(37);
    bad[13:7] = 7'b0000000;
    run_op(bad, enc(12), 1'b0);
    run_op(enc(-8), enc(11), 1'b0);

    run_op(enc(-63), enc(27), 1'b1);
    run_op(bad, enc(5), 1'b1);

    for (int i = 0; i < 30; i++) run_op(rand_op(), rand_op(), 1'b0);

    // start held high: back-to-back acceptance interval
    x_in  = enc(-17);
    y_in  = enc(53);
    model(x_in, y_in, ep, ee);
    start = 1'b1;
    @(posedge clk); #1;
    first  = -1;
    second = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = n;
        else begin
          second = n;
          break;
        end
      end
    end
    start = 1'b0;
    check("held_first_latency", 32'(first), 32'(WIDTH + 1));
    check("held_interval", 32'(second - first), 32'(WIDTH + 3));
    check("held_product", 32'(product), 32'(ep));
    @(posedge clk); #1;
    check("held_idle", 32'(busy), 32'd0);

    // reset in the middle of the step phase
    x_in  = enc(77);
    y_in  = enc(-31);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("midrst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(enc(77), enc(-31), 1'b0);
    run_op(rand_op(), rand_op(), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
